gbn_transmitter: RTL

GBN_TRANSMITTER -- requirements
Module: gbn_transmitter

---
 rtl/gbn_pkg.sv | 10 +
 rtl/gbn_window_buffer.sv | 22 ++
 rtl/gbn_transmitter.sv | 119 +++++++++++
 3 files changed

// File: rtl/gbn_pkg.sv
// gbn_pkg: shared state encoding and modulo sequence arithmetic for the Go-Back-N sender.
package gbn_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

   function automatic int seq_distance(input int a, input int b, input int width);
      return (a - b) & ((1 << width) - 1);
   endfunction

endpackage

// File: rtl/gbn_window_buffer.sv
// gbn_window_buffer: retransmit storage, one write port and one asynchronous read port.
module gbn_window_buffer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int AW    = 2
) (
   input  logic             aclk,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge aclk)
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/gbn_transmitter.sv
// gbn_transmitter: Go-Back-N ARQ sender with a WINDOW-deep retransmit buffer.
module gbn_transmitter
   import gbn_pkg::*;
#(
   parameter int VALUE_WIDTH    = 32,
   parameter int SEQ_WIDTH      = 3,
   parameter int WINDOW         = 4,
   parameter int TIMEOUT_CYCLES = 1200,
   parameter int MAX_RETRIES    = 8
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         s_val_tvalid,
   input  logic [VALUE_WIDTH-1:0]       s_val_tdata,
   output logic                         s_val_tready,
   output logic                         m_frm_valid,
   output logic [VALUE_WIDTH-1:0]       m_frm_value,
   output logic [SEQ_WIDTH-1:0]         m_frm_seq,
   input  logic                         m_frm_ready,
   input  logic                         s_ack_valid,
   input  logic [SEQ_WIDTH-1:0]         s_ack_seq,
   output logic                         s_ack_ready,
   output logic [$clog2(WINDOW+1)-1:0]  outstanding,
   output logic                         stale_ack,
   output logic                         error
);

   localparam int PW = WINDOW > 1 ? $clog2(WINDOW) : 1;
   localparam int CW = $clog2(WINDOW + 1);
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RW = $clog2(MAX_RETRIES + 1);

   state_t               state_q, state_d;
   logic [PW-1:0]        base_ptr_q, base_ptr_d, send_ptr_q, send_ptr_d, tail_ptr_q, tail_ptr_d;
   logic [SEQ_WIDTH-1:0] base_seq_q, base_seq_d, send_seq_q, send_seq_d, tail_seq_q, tail_seq_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [RW-1:0]        retry_q, retry_d;
   logic                 pend_q, pend_d, run_q, stale_q;
   logic                 wr_en, fire, ack_hit, ack_acc, timeout, give_up, rewind;
   int                   occ, in_flight, ack_off;

   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      return PW'(s >= WINDOW ? s - WINDOW : s);
   endfunction

   // Occupancy and in-flight counts come from sequence counters, which stay unambiguous when the window is full.
   assign occ          = seq_distance(int'(tail_seq_q), int'(base_seq_q), SEQ_WIDTH);
   assign in_flight    = seq_distance(int'(send_seq_q), int'(base_seq_q), SEQ_WIDTH);
   assign ack_off      = seq_distance(int'(s_ack_seq), int'(base_seq_q), SEQ_WIDTH);
   assign s_ack_ready  = run_q;
   assign s_val_tready = run_q && state_q != ERROR && occ < WINDOW;
   assign m_frm_valid  = state_q != ERROR && send_seq_q != tail_seq_q;
   assign m_frm_seq    = send_seq_q;
   assign outstanding  = CW'(occ);
   assign stale_ack    = stale_q;
   assign error        = state_q == ERROR;

   always_comb begin
      wr_en      = s_val_tvalid && s_val_tready;
      fire       = m_frm_valid && m_frm_ready;
      ack_hit    = s_ack_valid && s_ack_ready;
      ack_acc    = ack_hit && ack_off < in_flight;
      timeout    = state_q == WAIT && !ack_acc && timer_q == TW'(TIMEOUT_CYCLES - 1);
      give_up    = timeout && retry_q == RW'(MAX_RETRIES - 1);
      // A frame held on the bus must finish its handshake before send rewinds.
      rewind     = !ack_acc && ((timeout && (fire || !m_frm_valid)) || (pend_q && fire));
      pend_d     = !ack_acc && (pend_q ? !fire : timeout && m_frm_valid && !m_frm_ready);
      base_seq_d = ack_acc ? base_seq_q + SEQ_WIDTH'(ack_off + 1) : base_seq_q;
      base_ptr_d = ack_acc ? ptr_add(base_ptr_q, ack_off + 1) : base_ptr_q;
      send_seq_d = rewind ? base_seq_q : fire ? send_seq_q + SEQ_WIDTH'(1) : send_seq_q;
      send_ptr_d = rewind ? base_ptr_q : fire ? ptr_add(send_ptr_q, 1) : send_ptr_q;
      tail_seq_d = wr_en ? tail_seq_q + SEQ_WIDTH'(1) : tail_seq_q;
      tail_ptr_d = wr_en ? ptr_add(tail_ptr_q, 1) : tail_ptr_q;
      state_d    = (state_q == ERROR || give_up) ? ERROR : send_seq_d != base_seq_d ? WAIT : IDLE;
      timer_d    = (state_q != WAIT || state_d != WAIT || ack_acc || timeout) ? '0 : timer_q + TW'(1);
      retry_d    = ack_acc ? '0 : timeout ? retry_q + RW'(1) : retry_q;
   end

   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         state_q    <= IDLE;
         base_ptr_q <= '0;
         send_ptr_q <= '0;
         tail_ptr_q <= '0;
         base_seq_q <= '0;
         send_seq_q <= '0;
         tail_seq_q <= '0;
         timer_q    <= '0;
         retry_q    <= '0;
         pend_q     <= 1'b0;
         run_q      <= 1'b0;
         stale_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_ptr_q <= base_ptr_d;
         send_ptr_q <= send_ptr_d;
         tail_ptr_q <= tail_ptr_d;
         base_seq_q <= base_seq_d;
         send_seq_q <= send_seq_d;
         tail_seq_q <= tail_seq_d;
         timer_q    <= timer_d;
         retry_q    <= retry_d;
         pend_q     <= pend_d;
         run_q      <= 1'b1;
         stale_q    <= ack_hit && !ack_acc;
      end

   gbn_window_buffer #(.DEPTH(WINDOW), .WIDTH(VALUE_WIDTH), .AW(PW)) u_buf (
      .aclk      (aclk),
      .wr_en_i   (wr_en),
      .wr_addr_i (tail_ptr_q),
      .wr_data_i (s_val_tdata),
      .rd_addr_i (send_ptr_q),
      .rd_data_o (m_frm_value)
   );

endmodule
